ts_injection_descriptor_dispatch: RTL and testbench

- Downstream neighbour of the injection scheduler.
- Caches up to 32 time-sensitive packet descriptors, written by the host receive path into slots 0..31.
- Accepts the scheduler's 5-bit injection address with a one-cycle ack, fetches that slot's descriptor and forwards it to the forwarding stage with a valid/ready handshake.
- Frees the slot on forward and counts schedule misses (empty slot) and overwrites (slot written while still occupied).

---
 rtl/ts_injection_pkg.sv | 29 ++
 rtl/ts_descriptor_slot_cache.sv | 54 +++++
 rtl/ts_injection_descriptor_dispatch.sv | 134 +++++++++++++
 tb/tb_ts_injection_descriptor_dispatch.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ts_injection_pkg.sv
// Shared definitions for the time-sensitive injection descriptor path:
// cache geometry, dispatcher FSM encodings and descriptor field layout.
package ts_injection_pkg;

  localparam int TS_DESC_W     = 45;
  localparam int TS_SLOT_NUM   = 32;
  localparam int TS_SLOT_IDX_W = 5;
  localparam int TS_CNT_W      = 16;

  // Dispatcher states; encoding 3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    TDD_IDLE   = 2'd0,
    TDD_READ   = 2'd1,
    TDD_OUTPUT = 2'd2
  } tdd_state_e;

  // Descriptor field layout, shared with the forwarding stage.
  localparam int TS_DESC_BUFID_LSB   = 0;
  localparam int TS_DESC_BUFID_W     = 9;
  localparam int TS_DESC_PKTLEN_LSB  = 9;
  localparam int TS_DESC_PKTLEN_W    = 11;
  localparam int TS_DESC_OUTPORT_LSB = 20;
  localparam int TS_DESC_OUTPORT_W   = 8;
  localparam int TS_DESC_FLOWID_LSB  = 28;
  localparam int TS_DESC_FLOWID_W    = 14;
  localparam int TS_DESC_PRIO_LSB    = 42;
  localparam int TS_DESC_PRIO_W      = 3;

endpackage

// File: rtl/ts_descriptor_slot_cache.sv
// 32-slot descriptor store with per-slot valid bits. A host write and a
// dispatcher clear may target the same slot in one cycle; the write wins,
// and the read port still returns the content held before that edge.
module ts_descriptor_slot_cache
  import ts_injection_pkg::*;
#(
  parameter int DESC_W = TS_DESC_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr,
  input  logic [TS_SLOT_IDX_W-1:0] iv_waddr,
  input  logic [DESC_W-1:0]        iv_wdata,
  input  logic                     i_clr,
  input  logic [TS_SLOT_IDX_W-1:0] iv_raddr,
  output logic [DESC_W-1:0]        ov_rdata,
  output logic                     o_rvalid,
  output logic                     o_overwrite
);

  logic [DESC_W-1:0]      slot_mem [TS_SLOT_NUM];
  logic [TS_SLOT_NUM-1:0] valid_q;
  logic [TS_SLOT_NUM-1:0] valid_d;

  // Per-slot valid update: set on write, cleared on dispatch, write has priority.
  generate
    for (genvar gi = 0; gi < TS_SLOT_NUM; gi++) begin : g_slot
      localparam logic [TS_SLOT_IDX_W-1:0] SLOT_IDX = TS_SLOT_IDX_W'(gi);
      assign valid_d[gi] = (i_wr && (iv_waddr == SLOT_IDX)) ||
                           (valid_q[gi] && !(i_clr && (iv_raddr == SLOT_IDX)));
    end
  endgenerate

  // Descriptor storage; contents are left untouched by reset.
  always_ff @(posedge i_clk) begin
    if (i_wr) begin
      slot_mem[iv_waddr] <= iv_wdata;
    end
  end

  // Valid vector register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign ov_rdata    = slot_mem[iv_raddr];
  assign o_rvalid    = valid_q[iv_raddr];
  assign o_overwrite = i_wr && valid_q[iv_waddr];

endmodule

// File: rtl/ts_injection_descriptor_dispatch.sv
// Accepts injection addresses from the scheduler, fetches the cached
// descriptor for that slot and hands it to the forwarding stage, keeping
// saturating counts of empty-slot requests and slot overwrites.
module ts_injection_descriptor_dispatch
  import ts_injection_pkg::*;
#(
  parameter int DESC_W = TS_DESC_W,
  parameter int CNT_W  = TS_CNT_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [DESC_W-1:0]        iv_ts_descriptor_wdata,
  input  logic [TS_SLOT_IDX_W-1:0] iv_ts_descriptor_waddr,
  input  logic                     i_ts_descriptor_wr,
  input  logic [TS_SLOT_IDX_W-1:0] iv_ts_injection_addr,
  input  logic                     i_ts_injection_addr_wr,
  output logic                     o_ts_injection_addr_ack,
  output logic [DESC_W-1:0]        ov_ts_descriptor,
  output logic                     o_ts_descriptor_wr,
  input  logic                     i_ts_descriptor_ready,
  output logic [CNT_W-1:0]         ov_miss_cnt,
  output logic [CNT_W-1:0]         ov_overwrite_cnt,
  output logic [1:0]               ov_tdd_state
);

  tdd_state_e               state_q, state_d;
  logic [TS_SLOT_IDX_W-1:0] addr_q, addr_d;
  logic                     ack_q, ack_d;
  logic [DESC_W-1:0]        desc_q, desc_d;
  logic                     desc_wr_q, desc_wr_d;
  logic [CNT_W-1:0]         miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0]         ovw_cnt_q, ovw_cnt_d;

  logic                     slot_clr;
  logic [DESC_W-1:0]        slot_rdata;
  logic                     slot_valid;
  logic                     slot_overwrite;

  ts_descriptor_slot_cache #(
    .DESC_W (DESC_W)
  ) u_slot_cache (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_wr        (i_ts_descriptor_wr),
    .iv_waddr    (iv_ts_descriptor_waddr),
    .iv_wdata    (iv_ts_descriptor_wdata),
    .i_clr       (slot_clr),
    .iv_raddr    (addr_q),
    .ov_rdata    (slot_rdata),
    .o_rvalid    (slot_valid),
    .o_overwrite (slot_overwrite)
  );

  // Next-state, output and counter logic for the dispatcher.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    ack_d      = 1'b0;
    desc_d     = desc_q;
    desc_wr_d  = desc_wr_q;
    miss_cnt_d = miss_cnt_q;
    ovw_cnt_d  = ovw_cnt_q;
    slot_clr   = 1'b0;

    if (slot_overwrite && (ovw_cnt_q != '1)) begin
      ovw_cnt_d = ovw_cnt_q + CNT_W'(1);
    end

    case (state_q)
      TDD_IDLE: begin
        if (i_ts_injection_addr_wr) begin
          addr_d  = iv_ts_injection_addr;
          ack_d   = 1'b1;
          state_d = TDD_READ;
        end
      end
      TDD_READ: begin
        // The scheduler sees the ack this cycle, so its request is not re-sampled here.
        if (slot_valid) begin
          desc_d    = slot_rdata;
          desc_wr_d = 1'b1;
          slot_clr  = 1'b1;
          state_d   = TDD_OUTPUT;
        end else begin
          if (miss_cnt_q != '1) begin
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
          end
          state_d = TDD_IDLE;
        end
      end
      TDD_OUTPUT: begin
        if (i_ts_descriptor_ready) begin
          desc_wr_d = 1'b0;
          desc_d    = '0;
          state_d   = TDD_IDLE;
        end
      end
      default: begin
        desc_wr_d = 1'b0;
        desc_d    = '0;
        state_d   = TDD_IDLE;
      end
    endcase
  end

  // Dispatcher registers; reset abandons any descriptor in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= TDD_IDLE;
      addr_q     <= '0;
      ack_q      <= 1'b0;
      desc_q     <= '0;
      desc_wr_q  <= 1'b0;
      miss_cnt_q <= '0;
      ovw_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      ack_q      <= ack_d;
      desc_q     <= desc_d;
      desc_wr_q  <= desc_wr_d;
      miss_cnt_q <= miss_cnt_d;
      ovw_cnt_q  <= ovw_cnt_d;
    end
  end

  assign o_ts_injection_addr_ack = ack_q;
  assign ov_ts_descriptor        = desc_q;
  assign o_ts_descriptor_wr      = desc_wr_q;
  assign ov_miss_cnt             = miss_cnt_q;
  assign ov_overwrite_cnt        = ovw_cnt_q;
  assign ov_tdd_state            = state_q;

endmodule

// File: tb/tb_ts_injection_descriptor_dispatch.sv
// Directed bench for the injection descriptor dispatcher: hit, miss,
// back-pressure, overwrite, same-cycle write/clear and mid-transfer reset.
module tb_ts_injection_descriptor_dispatch;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [44:0] iv_ts_descriptor_wdata;
  logic [4:0]  iv_ts_descriptor_waddr;
  logic        i_ts_descriptor_wr;
  logic [4:0]  iv_ts_injection_addr;
  logic        i_ts_injection_addr_wr;
  logic        o_ts_injection_addr_ack;
  logic [44:0] ov_ts_descriptor;
  logic        o_ts_descriptor_wr;
  logic        i_ts_descriptor_ready;
  logic [15:0] ov_miss_cnt;
  logic [15:0] ov_overwrite_cnt;
  logic [1:0]  ov_tdd_state;

  int checks   = 0;
  int failures = 0;

  ts_injection_descriptor_dispatch dut (
    .i_clk                   (i_clk),
    .i_rst                   (i_rst),
    .iv_ts_descriptor_wdata  (iv_ts_descriptor_wdata),
    .iv_ts_descriptor_waddr  (iv_ts_descriptor_waddr),
    .i_ts_descriptor_wr      (i_ts_descriptor_wr),
    .iv_ts_injection_addr    (iv_ts_injection_addr),
    .i_ts_injection_addr_wr  (i_ts_injection_addr_wr),
    .o_ts_injection_addr_ack (o_ts_injection_addr_ack),
    .ov_ts_descriptor        (ov_ts_descriptor),
    .o_ts_descriptor_wr      (o_ts_descriptor_wr),
    .i_ts_descriptor_ready   (i_ts_descriptor_ready),
    .ov_miss_cnt             (ov_miss_cnt),
    .ov_overwrite_cnt        (ov_overwrite_cnt),
    .ov_tdd_state            (ov_tdd_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic write_slot(input logic [4:0] a, input logic [44:0] d);
    iv_ts_descriptor_waddr = a;
    iv_ts_descriptor_wdata = d;
    i_ts_descriptor_wr     = 1'b1;
    tick();
    i_ts_descriptor_wr     = 1'b0;
    $display("TXN write slot=%0d data=0x%0h", a, d);
  endtask

  // Raise a request, pass edge E0 and confirm the ack / READ state.
  task automatic send_req(input logic [4:0] a);
    iv_ts_injection_addr   = a;
    i_ts_injection_addr_wr = 1'b1;
    tick();
    check_val("req_ack", 64'(o_ts_injection_addr_ack), 64'd1);
    check_val("req_state_read", 64'(ov_tdd_state), 64'd1);
    i_ts_injection_addr_wr = 1'b0;
    $display("TXN request slot=%0d", a);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst                  = 1'b1;
    iv_ts_descriptor_wdata = '0;
    iv_ts_descriptor_waddr = '0;
    i_ts_descriptor_wr     = 1'b0;
    iv_ts_injection_addr   = '0;
    i_ts_injection_addr_wr = 1'b0;
    i_ts_descriptor_ready  = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;

    // Reset state
    check_val("rst_ack", 64'(o_ts_injection_addr_ack), 64'd0);
    check_val("rst_wr", 64'(o_ts_descriptor_wr), 64'd0);
    check_val("rst_desc", 64'(ov_ts_descriptor), 64'd0);
    check_val("rst_miss", 64'(ov_miss_cnt), 64'd0);
    check_val("rst_ovw", 64'(ov_overwrite_cnt), 64'd0);
    check_val("rst_state", 64'(ov_tdd_state), 64'd0);

    // Hit on slot 7 with ready high
    write_slot(5'd7, 45'h0_1234_5678);
    send_req(5'd7);
    check_val("hit7_wr_e0", 64'(o_ts_descriptor_wr), 64'd0);
    tick();
    check_val("hit7_ack_e1", 64'(o_ts_injection_addr_ack), 64'd0);
    check_val("hit7_wr_e1", 64'(o_ts_descriptor_wr), 64'd1);
    check_val("hit7_desc", 64'(ov_ts_descriptor), 64'h0_1234_5678);
    check_val("hit7_state", 64'(ov_tdd_state), 64'd2);
    tick();
    check_val("hit7_wr_done", 64'(o_ts_descriptor_wr), 64'd0);
    check_val("hit7_desc_zero", 64'(ov_ts_descriptor), 64'd0);
    check_val("hit7_idle", 64'(ov_tdd_state), 64'd0);
    // Slot 7 was freed, so a second request misses
    send_req(5'd7);
    tick();
    check_val("rereq7_wr", 64'(o_ts_descriptor_wr), 64'd0);
    check_val("rereq7_miss", 64'(ov_miss_cnt), 64'd1);

    // Miss on empty slot 3
    send_req(5'd3);
    tick();
    check_val("miss3_wr", 64'(o_ts_descriptor_wr), 64'd0);
    check_val("miss3_cnt", 64'(ov_miss_cnt), 64'd2);
    check_val("miss3_idle", 64'(ov_tdd_state), 64'd0);

    // Back-pressure on slot 5 while the scheduler asks for slot 6
    write_slot(5'd5, 45'h1555);
    write_slot(5'd6, 45'h1666);
    i_ts_descriptor_ready = 1'b0;
    send_req(5'd5);
    tick();
    check_val("bp5_wr", 64'(o_ts_descriptor_wr), 64'd1);
    check_val("bp5_desc", 64'(ov_ts_descriptor), 64'h1555);
    iv_ts_injection_addr   = 5'd6;
    i_ts_injection_addr_wr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("bp5_hold_wr", 64'(o_ts_descriptor_wr), 64'd1);
      check_val("bp5_hold_desc", 64'(ov_ts_descriptor), 64'h1555);
      check_val("bp5_no_ack", 64'(o_ts_injection_addr_ack), 64'd0);
    end
    i_ts_descriptor_ready = 1'b1;
    tick();
    check_val("bp5_release_wr", 64'(o_ts_descriptor_wr), 64'd0);
    check_val("bp5_release_ack", 64'(o_ts_injection_addr_ack), 64'd0);
    check_val("bp5_release_idle", 64'(ov_tdd_state), 64'd0);
    tick();
    check_val("req6_ack", 64'(o_ts_injection_addr_ack), 64'd1);
    i_ts_injection_addr_wr = 1'b0;
    $display("TXN request slot=6 (held)");
    tick();
    check_val("req6_wr", 64'(o_ts_descriptor_wr), 64'd1);
    check_val("req6_desc", 64'(ov_ts_descriptor), 64'h1666);
    tick();
    check_val("req6_done", 64'(o_ts_descriptor_wr), 64'd0);

    // Double write to slot 9
    write_slot(5'd9, 45'hAAAA);
    write_slot(5'd9, 45'hBBBB);
    check_val("ovw9_cnt", 64'(ov_overwrite_cnt), 64'd1);
    send_req(5'd9);
    tick();
    check_val("ovw9_desc", 64'(ov_ts_descriptor), 64'hBBBB);
    check_val("ovw9_wr", 64'(o_ts_descriptor_wr), 64'd1);
    tick();

    // Write to slot 2 in the same cycle its READ clears it
    write_slot(5'd2, 45'h222);
    send_req(5'd2);
    iv_ts_descriptor_waddr = 5'd2;
    iv_ts_descriptor_wdata = 45'h333;
    i_ts_descriptor_wr     = 1'b1;
    tick();
    i_ts_descriptor_wr     = 1'b0;
    $display("TXN write slot=2 data=0x333 (during READ)");
    check_val("wc2_old_desc", 64'(ov_ts_descriptor), 64'h222);
    check_val("wc2_wr", 64'(o_ts_descriptor_wr), 64'd1);
    check_val("wc2_ovw", 64'(ov_overwrite_cnt), 64'd2);
    tick();
    send_req(5'd2);
    tick();
    check_val("wc2_new_wr", 64'(o_ts_descriptor_wr), 64'd1);
    check_val("wc2_new_desc", 64'(ov_ts_descriptor), 64'h333);
    check_val("wc2_miss_same", 64'(ov_miss_cnt), 64'd2);
    tick();

    // Reset while a descriptor is waiting in OUTPUT
    i_ts_descriptor_ready = 1'b0;
    write_slot(5'd4, 45'h444);
    send_req(5'd4);
    tick();
    check_val("rst4_pre_wr", 64'(o_ts_descriptor_wr), 64'd1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check_val("rst4_wr", 64'(o_ts_descriptor_wr), 64'd0);
    check_val("rst4_desc", 64'(ov_ts_descriptor), 64'd0);
    check_val("rst4_miss", 64'(ov_miss_cnt), 64'd0);
    check_val("rst4_ovw", 64'(ov_overwrite_cnt), 64'd0);
    check_val("rst4_state", 64'(ov_tdd_state), 64'd0);
    check_val("rst4_ack", 64'(o_ts_injection_addr_ack), 64'd0);
    i_ts_descriptor_ready = 1'b1;
    send_req(5'd4);
    tick();
    check_val("post_rst_wr", 64'(o_ts_descriptor_wr), 64'd0);
    check_val("post_rst_miss", 64'(ov_miss_cnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
